// File: rtl/digit_feeder_pkg.sv
// Shared constants and FSM encoding for the digit-serial feeder and the PE array it drives.
package digit_feeder_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    localparam int F_M         = 163;
    localparam int F_DIGITS    = 8;
    localparam int F_NDIG      = ceil_div(F_M, F_DIGITS);
    localparam int F_FLUSH_CYC = 42;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADB = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/digit_shreg.sv
// Parallel-load register that shifts left one digit per enabled cycle and exposes its top digit.
module digit_shreg #(
    parameter int W = 168,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [D-1:0] top
);
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-D-1:0], {D{1'b0}}};
        end
    end

    assign top = q[W-1 -: D];

endmodule

// File: rtl/digit_feeder.sv
// Streams b, then a/g, most-significant digit first into the first PE, drains the array, then pulses done.
module digit_feeder
    import digit_feeder_pkg::*;
#(
    parameter int M         = F_M,
    parameter int DIGITS    = F_DIGITS,
    parameter int NDIG      = F_NDIG,
    parameter int FLUSH_CYC = F_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [M-1:0]      a,
    input  logic [M-1:0]      b,
    input  logic [M-1:0]      g,
    output logic              busy,
    output logic [DIGITS-1:0] a_dig,
    output logic [DIGITS-1:0] g_dig,
    output logic [DIGITS-1:0] b_dig,
    output logic [DIGITS-2:0] t_i_1_dig,
    output logic [DIGITS-2:0] t_i_2_dig,
    output logic              t_i_1_dig_0,
    output logic              ctr,
    output logic              done
);
    localparam int W = NDIG * DIGITS;

    state_t            state, state_nx;
    logic [4:0]        dig_cnt, dig_cnt_nx;
    logic [5:0]        fl_cnt, fl_cnt_nx;
    logic              accept, shift_b, shift_ag;
    logic              busy_nx, done_nx, ctr_nx;
    logic [DIGITS-1:0] a_nx, b_nx, g_nx;
    logic [DIGITS-1:0] a_top, b_top, g_top;

    // Operands are captured zero-extended so the top digit carries the pad bits as zeros.
    digit_shreg #(.W(W), .D(DIGITS)) u_a (
        .clk(clk), .rstn(rstn), .load(accept), .shift(shift_ag), .din(W'(a)), .top(a_top)
    );
    digit_shreg #(.W(W), .D(DIGITS)) u_b (
        .clk(clk), .rstn(rstn), .load(accept), .shift(shift_b), .din(W'(b)), .top(b_top)
    );
    digit_shreg #(.W(W), .D(DIGITS)) u_g (
        .clk(clk), .rstn(rstn), .load(accept), .shift(shift_ag), .din(W'(g)), .top(g_top)
    );

    // Outputs are registered one cycle behind the FSM, so the FSM reaches IDLE while
    // the last flush cycle is still on the outputs; a high busy in IDLE marks the done cycle.
    always_comb begin
        state_nx   = state;
        dig_cnt_nx = dig_cnt;
        fl_cnt_nx  = fl_cnt;
        accept     = 1'b0;
        shift_b    = 1'b0;
        shift_ag   = 1'b0;
        busy_nx    = 1'b1;
        done_nx    = 1'b0;
        ctr_nx     = 1'b0;
        a_nx       = '0;
        b_nx       = '0;
        g_nx       = '0;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (busy) begin
                    done_nx = 1'b1;
                end else if (start) begin
                    accept     = 1'b1;
                    busy_nx    = 1'b1;
                    state_nx   = LOADB;
                    dig_cnt_nx = '0;
                    fl_cnt_nx  = '0;
                end
            end
            LOADB: begin
                b_nx    = b_top;
                shift_b = 1'b1;
                if (dig_cnt == 5'(NDIG - 1)) begin
                    state_nx   = RUN;
                    dig_cnt_nx = '0;
                end else begin
                    dig_cnt_nx = dig_cnt + 5'd1;
                end
            end
            RUN: begin
                a_nx     = a_top;
                g_nx     = g_top;
                shift_ag = 1'b1;
                ctr_nx   = 1'b1;
                if (dig_cnt == 5'(NDIG - 1)) begin
                    state_nx   = FLUSH;
                    dig_cnt_nx = '0;
                end else begin
                    dig_cnt_nx = dig_cnt + 5'd1;
                end
            end
            FLUSH: begin
                ctr_nx = 1'b1;
                if (fl_cnt == 6'(FLUSH_CYC - 1)) begin
                    state_nx   = IDLE;
                    fl_cnt_nx  = '0;
                    dig_cnt_nx = '0;
                end else begin
                    fl_cnt_nx = fl_cnt + 6'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            dig_cnt <= '0;
            fl_cnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ctr     <= 1'b0;
            a_dig   <= '0;
            b_dig   <= '0;
            g_dig   <= '0;
        end else begin
            state   <= state_nx;
            dig_cnt <= dig_cnt_nx;
            fl_cnt  <= fl_cnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            ctr     <= ctr_nx;
            a_dig   <= a_nx;
            b_dig   <= b_nx;
            g_dig   <= g_nx;
        end
    end

    // The first PE has no upstream neighbour, so its partial-sum inputs are tied off.
    assign t_i_1_dig   = '0;
    assign t_i_2_dig   = '0;
    assign t_i_1_dig_0 = 1'b0;

endmodule
